// File: rtl/dcache_pkg.sv
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared state encoding and default geometry for the data cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int DEF_SETS  = 64;
    localparam int DEF_WORDS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_FILL    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESPOND = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ============================================================================
// Module   : dcache_array
// Purpose  : Tag, valid and data storage for a direct-mapped cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         flush_all,
    input  logic [$clog2(SETS)-1:0]                      rd_index,
    input  logic [$clog2(WORDS)-1:0]                     rd_offset,
    output logic                                         rd_valid,
    output logic [63-3-$clog2(WORDS)-$clog2(SETS):0]     rd_tag,
    output logic [63:0]                                  rd_word,
    input  logic                                         word_we,
    input  logic [$clog2(SETS)-1:0]                      wr_index,
    input  logic [$clog2(WORDS)-1:0]                     wr_offset,
    input  logic [63:0]                                  wr_word,
    input  logic                                         tag_we,
    input  logic [63-3-$clog2(WORDS)-$clog2(SETS):0]     wr_tag
);

    localparam int TAG_W = 64 - 3 - $clog2(WORDS) - $clog2(SETS);

    logic [63:0]      r_data [SETS][WORDS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;

    always_ff @(posedge clk) begin
        if (reset || flush_all) begin
            r_valid <= '0;
        end else if (tag_we) begin
            r_valid[wr_index] <= 1'b1;
        end
    end

    // Contents are not reset; validity alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (word_we) begin
            r_data[wr_index][wr_offset] <= wr_word;
        end
        if (tag_we) begin
            r_tag[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_word  = r_data[rd_index][rd_offset];

endmodule

`default_nettype wire

// File: rtl/dcache.sv
// ============================================================================
// Module   : dcache
// Purpose  : Direct-mapped write-through, no-write-allocate data cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache
    import dcache_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcache_en,
    input  logic        dcache_wren,
    input  logic [63:0] dcache_addr,
    input  logic [63:0] dcache_wdata,
    output logic [63:0] dcache_rdata,
    output logic        dcache_done,
    input  logic        dcache_flush,
    output logic        mem_req,
    output logic        mem_wren,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 64 - 3 - OFF_W - IDX_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [63:3]       r_addr;
    logic [63:0]       r_wdata;
    logic [63:0]       r_rdata;
    logic              r_wren;
    logic [OFF_W-1:0]  r_beat;
    logic              r_flush_pend;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [63:0]       w_rd_word;
    logic              w_hit;
    logic              w_last;
    logic              w_ack_fill;
    logic              w_ack_write;
    logic              w_flush_now;
    logic              w_unused_addr;

    assign w_off         = r_addr[3 +: OFF_W];
    assign w_idx         = r_addr[3+OFF_W +: IDX_W];
    assign w_tag         = r_addr[63 -: TAG_W];
    assign w_hit         = w_rd_valid && (w_rd_tag == w_tag);
    assign w_last        = (r_beat == OFF_W'(WORDS-1));
    assign w_ack_fill    = (r_state == ST_FILL)  && mem_ack;
    assign w_ack_write   = (r_state == ST_WRITE) && mem_ack;
    assign w_flush_now   = (r_state == ST_IDLE)  && (dcache_flush || r_flush_pend);
    assign w_unused_addr = ^dcache_addr[2:0];

    dcache_array #(
        .SETS  (SETS),
        .WORDS (WORDS)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .flush_all (w_flush_now),
        .rd_index  (w_idx),
        .rd_offset (w_off),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_word   (w_rd_word),
        .word_we   (w_ack_fill || (w_ack_write && w_hit)),
        .wr_index  (w_idx),
        .wr_offset ((r_state == ST_FILL) ? r_beat : w_off),
        .wr_word   ((r_state == ST_FILL) ? mem_rdata : r_wdata),
        .tag_we    (w_ack_fill && w_last),
        .wr_tag    (w_tag)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (dcache_en) w_state_nxt = ST_LOOKUP;
            ST_LOOKUP: begin
                if (r_wren)     w_state_nxt = ST_WRITE;
                else if (w_hit) w_state_nxt = ST_RESPOND;
                else            w_state_nxt = ST_FILL;
            end
            ST_FILL:    if (mem_ack && w_last) w_state_nxt = ST_RESPOND;
            ST_WRITE:   if (mem_ack) w_state_nxt = ST_RESPOND;
            ST_RESPOND: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_wren       <= 1'b0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && dcache_en) begin
                r_addr  <= dcache_addr[63:3];
                r_wren  <= dcache_wren;
                r_wdata <= dcache_wdata;
            end
            // A flush arriving mid-transaction waits for IDLE so the fill still completes.
            if (w_flush_now) begin
                r_flush_pend <= 1'b0;
            end else if (dcache_flush) begin
                r_flush_pend <= 1'b1;
            end
            if (r_state == ST_LOOKUP) begin
                r_beat  <= '0;
                r_rdata <= (!r_wren && w_hit) ? w_rd_word : 64'd0;
            end
            if (w_ack_fill) begin
                r_beat <= r_beat + OFF_W'(1);
                if (r_beat == w_off) begin
                    r_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_req      = (r_state == ST_FILL) || (r_state == ST_WRITE);
    assign mem_wren     = (r_state == ST_WRITE);
    assign mem_addr     = (r_state == ST_FILL)  ? {r_addr[63:3+OFF_W], r_beat, 3'b000} :
                          (r_state == ST_WRITE) ? {r_addr, 3'b000} : 64'd0;
    assign mem_wdata    = (r_state == ST_WRITE) ? r_wdata : 64'd0;
    assign dcache_done  = (r_state == ST_RESPOND);
    assign dcache_rdata = (r_state == ST_RESPOND) ? r_rdata : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_dcache.sv
// ============================================================================
// Module   : tb_dcache
// Purpose  : Scoreboard bench for dcache with a one-cycle-delay memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcache_en, dcache_wren, dcache_flush;
    logic [63:0] dcache_addr, dcache_wdata, dcache_rdata;
    logic        dcache_done;
    logic        mem_req, mem_wren, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache #(.SETS(64), .WORDS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .dcache_en    (dcache_en),
        .dcache_wren  (dcache_wren),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .dcache_rdata (dcache_rdata),
        .dcache_done  (dcache_done),
        .dcache_flush (dcache_flush),
        .mem_req      (mem_req),
        .mem_wren     (mem_wren),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    typedef struct packed {
        logic        wren;
        logic [63:0] addr;
        logic [63:0] wdata;
    } bus_t;

    int          checks  = 0;
    int          errors  = 0;
    int          ack_cnt = 0;
    bus_t        exp_bus [$];
    logic [63:0] exp_rd  [$];
    logic [63:0] bmem    [logic [63:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Background memory contents: 0xA0+word-in-line, with a line-region marker above.
    function automatic logic [63:0] init_word(input logic [63:0] a);
        return ((a >> 13) << 16) | (64'hA0 + {61'd0, a[5:3]});
    endfunction

    function automatic logic [63:0] rd_mem(input logic [63:0] a);
        logic [63:0] al;
        al = {a[63:3], 3'b000};
        return bmem.exists(al) ? bmem[al] : init_word(al);
    endfunction

    task automatic push_beats(input logic [63:0] line, input int n);
        for (int b = 0; b < n; b++) begin
            exp_bus.push_back('{wren: 1'b0, addr: line + 64'(8*b), wdata: 64'd0});
        end
    endtask

    task automatic push_write(input logic [63:0] a, input logic [63:0] d);
        exp_bus.push_back('{wren: 1'b1, addr: {a[63:3], 3'b000}, wdata: d});
    endtask

    // Memory responder: acks every request one idle cycle after it appears.
    initial begin
        bit   seen;
        bus_t e;
        seen      = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!seen) begin
                    seen = 1'b1;
                end else begin
                    seen = 1'b0;
                    ack_cnt++;
                    chk("bus_expected", 64'(exp_bus.size() != 0), 64'd1);
                    if (exp_bus.size() != 0) begin
                        e = exp_bus.pop_front();
                        chk("bus_wren", 64'(mem_wren), 64'(e.wren));
                        chk("bus_addr", mem_addr, e.addr);
                        if (e.wren) chk("bus_wdata", mem_wdata, e.wdata);
                    end
                    if (mem_wren) bmem[mem_addr] = mem_wdata;
                    else          mem_rdata = rd_mem(mem_addr);
                    mem_ack = 1'b1;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic do_op(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                         input bit exp_hit, input bit with_flush);
        int n;
        dcache_en    = 1'b1;
        dcache_wren  = wr;
        dcache_addr  = a;
        dcache_wdata = wd;
        dcache_flush = with_flush;
        exp_rd.push_back(wr ? 64'd0 : rd_mem(a));
        @(posedge clk); #1;
        dcache_en    = 1'b0;
        dcache_flush = 1'b0;
        n = 1;
        while (!dcache_done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!dcache_done) begin
            chk("done_timeout", 64'(dcache_done), 64'd1);
            exp_rd.delete();
        end else begin
            chk("rdata", dcache_rdata, exp_rd.pop_front());
            if (exp_hit) chk("hit_latency", 64'(n), 64'd2);
            @(posedge clk); #1;
            chk("done_pulse", 64'(dcache_done), 64'd0);
        end
        chk("bus_left", 64'(exp_bus.size()), 64'd0);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_done", 64'(dcache_done), 64'd0);
            chk("idle_req", 64'(mem_req), 64'd0);
        end
    endtask

    task automatic wait_acks(input int target);
        int n;
        n = 0;
        while (ack_cnt < target && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("ack_wait", 64'(ack_cnt >= target), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset        = 1'b1;
        dcache_en    = 1'b0;
        dcache_wren  = 1'b0;
        dcache_flush = 1'b0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",  64'(dcache_done), 64'd0);
        chk("rst_rdata", dcache_rdata, 64'd0);
        chk("rst_req",   64'(mem_req), 64'd0);
        chk("rst_wren",  64'(mem_wren), 64'd0);
        chk("rst_addr",  mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Cold load, then hit in the same line
        push_beats(64'h1000, 8);
        do_op(1'b0, 64'h1008, 64'd0, 1'b0, 1'b0);
        do_op(1'b0, 64'h1038, 64'd0, 1'b1, 1'b0);

        // Store hit updates line; following load hits
        push_write(64'h1010, 64'hDEAD);
        do_op(1'b1, 64'h1010, 64'hDEAD, 1'b0, 1'b0);
        do_op(1'b0, 64'h1010, 64'd0, 1'b1, 1'b0);

        // Store miss does not allocate; a request during the fill is dropped
        push_write(64'h9000, 64'h1234);
        do_op(1'b1, 64'h9000, 64'h1234, 1'b0, 1'b0);
        push_beats(64'h9000, 8);
        fork
            do_op(1'b0, 64'h9000, 64'd0, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                dcache_en   = 1'b1;
                dcache_addr = 64'h1000;
                @(posedge clk); #1;
                dcache_en   = 1'b0;
            end
        join
        idle_check(3);
        do_op(1'b0, 64'h9008, 64'd0, 1'b1, 1'b0);

        // Flush in IDLE together with a request: request misses after the clear
        push_beats(64'h1000, 8);
        do_op(1'b0, 64'h1038, 64'd0, 1'b0, 1'b1);
        do_op(1'b0, 64'h1010, 64'd0, 1'b1, 1'b0);

        // Flush during a fill is deferred until the request completes
        push_beats(64'h2000, 8);
        base = ack_cnt;
        fork
            do_op(1'b0, 64'h2000, 64'd0, 1'b0, 1'b0);
            begin
                wait_acks(base + 4);
                dcache_flush = 1'b1;
                @(posedge clk); #2;
                dcache_flush = 1'b0;
            end
        join
        idle_check(2);
        push_beats(64'h2000, 8);
        do_op(1'b0, 64'h2018, 64'd0, 1'b0, 1'b0);
        push_beats(64'h1000, 8);
        do_op(1'b0, 64'h1000, 64'd0, 1'b0, 1'b0);

        // Reset after the beat-4 ack abandons the fill
        base = ack_cnt;
        push_beats(64'h4000, 5);
        dcache_en    = 1'b1;
        dcache_wren  = 1'b0;
        dcache_addr  = 64'h4010;
        @(posedge clk); #1;
        dcache_en    = 1'b0;
        wait_acks(base + 5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_req",  64'(mem_req), 64'd0);
        chk("rst_mid_done", 64'(dcache_done), 64'd0);
        reset = 1'b0;
        idle_check(4);
        chk("rst_bus_left", 64'(exp_bus.size()), 64'd0);
        push_beats(64'h4000, 8);
        do_op(1'b0, 64'h4010, 64'd0, 1'b0, 1'b0);
        do_op(1'b0, 64'h4038, 64'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter SETS, default 64, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter WORDS, default 8, 64-bit words per line (power of two).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dcache_en  input  1  one-cycle request strobe from the Mem stage.
REQ-006 dcache_wren  input  1  qualifies dcache_en; 1 = store, 0 = load.
REQ-007 dcache_addr  input  64  byte address; bits [2:0] ignored.
REQ-008 dcache_wdata  input  64  store data, valid with dcache_en.
REQ-009 dcache_rdata  output  64  load data, valid only while dcache_done=1.
REQ-010 dcache_done  output  1  one-cycle completion pulse, for loads and stores.
REQ-011 dcache_flush  input  1  one-cycle pulse that invalidates all lines.
REQ-012 mem_req  output  1  memory-bus request, held until acked.
REQ-013 mem_wren  output  1  1 = bus write, 0 = bus read; stable while mem_req=1.
REQ-014 mem_addr  output  64  8-byte-aligned bus address; stable while mem_req=1.
REQ-015 mem_wdata  output  64  bus write data; stable while mem_req=1.
REQ-016 mem_rdata  input  64  bus read data, valid when mem_ack=1.
REQ-017 mem_ack  input  1  one-cycle beat acknowledge.

Function
REQ-018 Address split SHALL be: offset = addr[3 +: log2(WORDS)], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-019 FSM states SHALL be IDLE, LOOKUP, FILL, WRITE, RESPOND.
REQ-020 IDLE: dcache_en=1 SHALL latch addr, wren and wdata and go to LOOKUP; all other inputs except flush are ignored.
REQ-021 dcache_en in any state other than IDLE SHALL be dropped without a response.
REQ-022 LOOKUP, load hit (valid and tag match): go to RESPOND with the hit word, so dcache_done is high exactly 2 cycles after the dcache_en cycle.
REQ-023 LOOKUP, load miss: go to FILL with beat counter = 0.
REQ-024 LOOKUP, store: go to WRITE; write-through with no write-allocate.
REQ-025 FILL: mem_req=1, mem_wren=0, mem_addr = {tag, index, beat, 3'b000}, beats issued in order 0..WORDS-1.
REQ-026 FILL: each mem_ack SHALL store mem_rdata into the line at the current beat and increment beat.
REQ-027 FILL: after an ack, mem_req SHALL stay high for the next beat with the new address in the following cycle.
REQ-028 FILL: on the ack of beat WORDS-1, set valid, write the tag, go to RESPOND and return the latched-offset word.
REQ-029 WRITE: mem_req=1, mem_wren=1, mem_addr = latched address with [2:0]=0, mem_wdata = latched data.
REQ-030 WRITE: on mem_ack, if the line hits, update the cached word, then go to RESPOND; a miss leaves the arrays untouched.
REQ-031 RESPOND: dcache_done=1 for exactly one cycle, dcache_rdata = word for loads and 0 for stores, then return to IDLE.
REQ-032 mem_req SHALL be 0 in IDLE, LOOKUP and RESPOND.
REQ-033 Flush in IDLE SHALL clear all valid bits at that edge; a dcache_en in the same cycle is accepted and looked up after the clear.
REQ-034 Flush outside IDLE SHALL be held pending and applied on the first IDLE cycle; the in-flight request completes normally, and its fill still sets valid before the pending clear.
REQ-035 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-036 Reset SHALL force state=IDLE, all valid bits=0, pending flush=0, beat=0, dcache_done=0, dcache_rdata=0, mem_req=0, mem_wren=0, mem_addr=0, mem_wdata=0.
REQ-037 Reset mid-FILL or mid-WRITE SHALL abandon the transaction: mem_req=0 next cycle and no dcache_done is issued; tag and data contents need not be cleared.

Structure
REQ-038 The FSM state enum and the SETS/WORDS defaults SHALL live in a shared header alongside micro_op.svh.
REQ-039 Tag, valid and data storage SHALL be a sub-module dcache_array (read port plus one word-write port plus tag/valid write), instantiated once.

Verification
REQ-040 Cold load at 0x1008 with the bus returning 0xA0+beat after 1-cycle ack delay -> 8 reads at 0x1000..0x1038; done with rdata=0xA1.
REQ-041 Repeat load at 0x1038 after REQ-040 -> no mem_req, done 2 cycles after en, rdata=0xA7.
REQ-042 Store 0xDEAD to 0x1010, then load 0x1010 -> one bus write (addr 0x1010, wdata 0xDEAD), done; load hits with rdata=0xDEAD and no bus read.
REQ-043 Store to uncached 0x9000, then load 0x9000 -> bus write then a full 8-beat fill (no allocate on store).
REQ-044 Flush pulsed during beat 3 of a fill to 0x2000 -> fill completes and done is returned; the next load to 0x2000 misses and refills.
REQ-045 Reset asserted after beat 4 ack -> mem_req=0 next cycle, no done; the next load to the same line performs a full 8-beat fill.
